gcd_arbiter: RTL and testbench
==============================

GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter WIDTH, default 32, operand and result width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  N_REQ  per-requester request-valid flags.
REQ-006 req_a  input  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  N_REQ*WIDTH  operand B; same packing as req_a.
REQ-008 req_ready  output  N_REQ  one-hot grant; a handshake occurs when req_valid[i] and req_ready[i] are both 1.
REQ-009 resp_valid  output  1  one-cycle pulse when a result is presented.
REQ-010 resp_id  output  3  index of the requester that owns the result.
REQ-011 resp_gcd  output  WIDTH  GCD result.
REQ-012 busy  output  1  high in LOAD, RUN and DONE.

Function
REQ-013 FSM states: IDLE, LOAD, RUN, DONE.
REQ-014 IDLE, grant selection:
- Drive req_ready combinationally, one-hot, to the round-robin winner among the requesters with req_valid set.
- Search starts at index last_grant+1 and wraps modulo N_REQ.
- Drive req_ready all-zero when no requester is valid.
REQ-015 IDLE, on handshake:
- Capture the winner's A and B operands into the engine.
- Latch the winner index into resp_id.
- Set last_grant to the winner.
- Move to LOAD.
REQ-016 LOAD: pulse engine start for one cycle, then move to RUN; req_ready stays all-zero outside IDLE.
REQ-017 RUN, subtractive Euclid, one step per cycle:
- If y==0, the result is x; engine done.
- Else if x==0, the result is y; engine done.
- Else if x>y, x<=x-y.
- Else y<=y-x.
REQ-018 RUN -> DONE on the cycle after engine done asserts; resp_gcd holds the engine result.
REQ-019 DONE:
- Assert resp_valid for exactly one cycle.
- resp_gcd and resp_id hold their values until the next response.
- Move to IDLE.
REQ-020 Zero operands: gcd(0,0)=0; gcd(0,b)=b; gcd(a,0)=a. None of these may hang the engine.
REQ-021 Latency from handshake to resp_valid is 3 + S cycles, where S is the number of subtraction steps. For a=b, S=1, giving 4 cycles.
REQ-022 No backpressure on responses; the consumer samples when resp_valid=1.
REQ-023 A requester that drops req_valid before its handshake is not served and does not move last_grant.
REQ-024 Requests arriving during LOAD, RUN or DONE wait; they are not lost, provided req_valid stays held.
REQ-025 Operand arithmetic is unsigned WIDTH-bit; subtraction never underflows, because the larger operand is always the minuend.

Reset
REQ-026 While reset_n=0, outputs and state take these values:
- state=IDLE.
- last_grant=N_REQ-1, so requester 0 wins first.
- resp_valid=0, resp_id=0, resp_gcd=0, busy=0.
- Engine x=0, y=0, done=0.
REQ-027 Reset asserted mid-computation aborts the operation with no resp_valid. The aborted requester must re-request.
REQ-028 After reset_n deasserts, the first grant can occur in the first clock cycle.

Structure
REQ-029 A shared package gcd_pkg holds:
- the state enum (IDLE, LOAD, RUN, DONE);
- DEFAULT_WIDTH=32;
- ID_W=3.
REQ-030 One sub-module, gcd_engine, holds the REQ-017 datapath and exposes start, a, b, done and result. The arbiter instantiates it once.

Verification
REQ-031 Single request: requester 0 sends a=48, b=18 -> resp_gcd=6, resp_id=0, one resp_valid pulse.
REQ-032 Contention: all 4 requesters valid and held, operands (12,8),(9,6),(35,14),(17,5) -> responses in order id 0,1,2,3 with gcd 4,3,7,1.
REQ-033 Round-robin fairness: requesters 1 and 3 assert continuously for 6 transactions -> grant sequence alternates 1,3,1,3,1,3.
REQ-034 Zero operands: (0,0) -> 0; (0,25) -> 25; (40,0) -> 40; each completes within 5 cycles of its handshake.
REQ-035 Reset mid-RUN: reset_n pulsed low while a=0xFFFFFFFF, b=1 is running -> no resp_valid, busy=0; a following (10,4) request returns 2 with id 0.
REQ-036 Latency: a=b=7 -> resp_valid exactly 4 cycles after the handshake cycle.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD arbiter and its subtractive engine.
package gcd_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned ID_W          = 3;
  localparam int unsigned MAX_REQ       = 1 << ID_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/gcd_engine.sv
// Subtractive Euclid engine: one step per cycle after start, done flags the terminal operand pair.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             running_q, running_d;

  // done is combinational so the terminal check costs no extra cycle beyond the last step.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    running_d = running_q;
    done      = running_q && ((x_q == '0) || (y_q == '0));
    result    = (y_q == '0) ? x_q : y_q;
    if (start) begin
      x_d       = a;
      y_d       = b;
      running_d = 1'b1;
    end else if (running_q) begin
      if (done) begin
        running_d = 1'b0;
      end else if (x_q > y_q) begin
        x_d = x_q - y_q;
      end else begin
        y_d = y_q - x_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q       <= '0;
      y_q       <= '0;
      running_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      running_q <= running_d;
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that serves one GCD request at a time through a shared engine.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   resp_valid,
  output logic [ID_W-1:0]        resp_id,
  output logic [WIDTH-1:0]       resp_gcd,
  output logic                   busy
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_gcd_q, resp_gcd_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;

  logic             any_valid;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  cand_idx;
  int unsigned      cand;
  logic [MAX_REQ-1:0] valid_ext;
  logic [WIDTH-1:0] sel_a, sel_b;

  logic             eng_start;
  logic             eng_done;
  logic [WIDTH-1:0] eng_result;

  // Search from last_grant+1, wrapping modulo N_REQ; first valid requester wins.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    cand      = 0;
    cand_idx  = '0;
    valid_ext = MAX_REQ'(req_valid);
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand     = (32'(last_grant_q) + k) % N_REQ;
      cand_idx = ID_W'(cand);
      if (!any_valid && valid_ext[cand_idx]) begin
        any_valid = 1'b1;
        winner    = cand_idx;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == winner) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    resp_id_d    = resp_id_q;
    resp_gcd_d   = resp_gcd_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    eng_start    = 1'b0;
    req_ready    = '0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          req_ready    = N_REQ'(1) << winner;
          op_a_d       = sel_a;
          op_b_d       = sel_b;
          owner_d      = winner;
          last_grant_d = winner;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        eng_start = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        // Result and owner are published together so resp_id/resp_gcd stay stable between responses.
        if (eng_done) begin
          resp_gcd_d = eng_result;
          resp_id_d  = owner_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      owner_q      <= '0;
      resp_id_q    <= '0;
      resp_gcd_q   <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      resp_id_q    <= resp_id_d;
      resp_gcd_q   <= resp_gcd_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
    end
  end

  gcd_engine #(
    .WIDTH (WIDTH)
  ) u_engine (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (eng_start),
    .a       (op_a_q),
    .b       (op_b_q),
    .done    (eng_done),
    .result  (eng_result)
  );

  assign resp_valid = (state_q == DONE);
  assign resp_id    = resp_id_q;
  assign resp_gcd   = resp_gcd_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed, table-driven bench for gcd_arbiter with hand-computed results and latencies.
module tb_gcd_arbiter;
  import gcd_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR*W-1:0]   req_a;
  logic [NR*W-1:0]   req_b;
  logic [NR-1:0]     req_ready;
  logic              resp_valid;
  logic [ID_W-1:0]   resp_id;
  logic [W-1:0]      resp_gcd;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] gcd;
    int        lat;
  } vec_t;

  vec_t vecs[10];

  gcd_arbiter #(
    .N_REQ (NR),
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_gcd   (resp_gcd),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Returns the granted index once a handshake is pending on the next rising edge.
  task automatic wait_grant(output int idx, output bit ok);
    ok  = 1'b0;
    idx = -1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if ((req_ready & req_valid) != '0) begin
        for (int i = 0; i < NR; i++) if (req_ready[i]) idx = i;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Counts cycles after the handshake edge until resp_valid is seen.
  task automatic wait_resp(output int lat, output bit ok);
    ok  = 1'b0;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_single(input vec_t v);
    int idx, lat;
    bit ok;
    @(negedge clk);
    req_a[v.id*W +: W] = v.a;
    req_b[v.id*W +: W] = v.b;
    req_valid          = NR'(1) << v.id;
    wait_grant(idx, ok);
    check("grant timeout", 64'(ok), 64'd1);
    check("grant id", 64'(idx), 64'(v.id));
    @(posedge clk);
    #1 req_valid = '0;
    wait_resp(lat, ok);
    check("resp timeout", 64'(ok), 64'd1);
    check("resp_gcd", 64'(resp_gcd), 64'(v.gcd));
    check("resp_id", 64'(resp_id), 64'(v.id));
    check("latency", 64'(lat), 64'(v.lat));
    @(negedge clk);
    check("resp_valid pulse width", 64'(resp_valid), 64'd0);
  endtask

  initial begin : main
    int        idx, lat, pulses;
    bit        ok;
    int        exp_seq[6];
    logic [31:0] ca[4];
    logic [31:0] cb[4];
    logic [31:0] cg[4];

    vecs[0] = '{0, 32'd48, 32'd18, 32'd6,  8};
    vecs[1] = '{0, 32'd7,  32'd7,  32'd7,  4};
    vecs[2] = '{0, 32'd0,  32'd0,  32'd0,  3};
    vecs[3] = '{0, 32'd0,  32'd25, 32'd25, 3};
    vecs[4] = '{0, 32'd40, 32'd0,  32'd40, 3};
    vecs[5] = '{2, 32'd35, 32'd14, 32'd7,  7};
    vecs[6] = '{3, 32'd17, 32'd5,  32'd1,  10};
    vecs[7] = '{1, 32'd9,  32'd6,  32'd3,  6};
    vecs[8] = '{1, 32'd12, 32'd8,  32'd4,  6};
    vecs[9] = '{2, 32'd25, 32'd0,  32'd25, 3};

    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    do_reset();
    #1;
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset resp_id", 64'(resp_id), 64'd0);
    check("reset resp_gcd", 64'(resp_gcd), 64'd0);
    check("reset ready idle", 64'(req_ready), 64'd0);
    req_valid = 4'hF;
    #1;
    check("first grant after reset", 64'(req_ready), 64'd1);
    req_valid = '0;

    for (int i = 0; i < 10; i++) run_single(vecs[i]);

    // Contention: all four held valid until served.
    do_reset();
    ca = '{32'd12, 32'd9, 32'd35, 32'd17};
    cb = '{32'd8,  32'd6, 32'd14, 32'd5};
    cg = '{32'd4,  32'd3, 32'd7,  32'd1};
    for (int i = 0; i < NR; i++) begin
      req_a[i*W +: W] = ca[i];
      req_b[i*W +: W] = cb[i];
    end
    req_valid = 4'hF;
    for (int n = 0; n < NR; n++) begin
      wait_grant(idx, ok);
      check("contention grant timeout", 64'(ok), 64'd1);
      check("contention grant order", 64'(idx), 64'(n));
      @(posedge clk);
      #1;
      if (idx >= 0) req_valid[idx] = 1'b0;
      wait_resp(lat, ok);
      check("contention resp timeout", 64'(ok), 64'd1);
      check("contention resp_id", 64'(resp_id), 64'(n));
      check("contention resp_gcd", 64'(resp_gcd), 64'(cg[n]));
    end

    // Fairness: requesters 1 and 3 held continuously.
    exp_seq = '{1, 3, 1, 3, 1, 3};
    for (int i = 0; i < NR; i++) begin
      req_a[i*W +: W] = 32'd6;
      req_b[i*W +: W] = 32'd4;
    end
    req_valid = 4'b1010;
    for (int n = 0; n < 6; n++) begin
      wait_grant(idx, ok);
      check("fair grant timeout", 64'(ok), 64'd1);
      check("fair grant seq", 64'(idx), 64'(exp_seq[n]));
      @(posedge clk);
      #1;
      check("ready low while busy", 64'(req_ready), 64'd0);
      wait_resp(lat, ok);
      check("fair resp timeout", 64'(ok), 64'd1);
      check("fair resp_gcd", 64'(resp_gcd), 64'd2);
      check("fair resp_id", 64'(resp_id), 64'(exp_seq[n]));
    end
    req_valid = '0;

    // Reset in the middle of a very long computation.
    do_reset();
    req_a[0 +: W] = 32'hFFFF_FFFF;
    req_b[0 +: W] = 32'd1;
    req_valid     = 4'b0001;
    wait_grant(idx, ok);
    check("long grant", 64'(idx), 64'd0);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (10) @(negedge clk);
    check("busy mid-run", 64'(busy), 64'd1);
    check("no resp mid-run", 64'(resp_valid), 64'd0);
    reset_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort resp_valid", 64'(resp_valid), 64'd0);
    check("abort resp_gcd", 64'(resp_gcd), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses  = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("stray resp after abort", 64'(pulses), 64'd0);
    check("idle after abort", 64'(busy), 64'd0);
    run_single('{0, 32'd10, 32'd4, 32'd2, 7});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
